// File: rtl/floor_pkg.sv
// Shared constants and types for the floor renderer slice.
// Used by floor_addr_gen and floor_renderer (optional macro FLOOR_FRAME_LATCH_EN lives in the top).
package floor_pkg;

  localparam int SCREEN_W        = 640;
  localparam int FLOOR_Y_TOP     = 400;
  localparam int FLOOR_HEIGHT    = 80;
  localparam int COLOR_W         = 24;
  localparam int FLOOR_ROM_DEPTH = FLOOR_HEIGHT * SCREEN_W;

  localparam logic [COLOR_W-1:0] TRANSPARENT_KEY = 24'hFF00FF;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [15:0]        floor_addr_t;

  // The animator may hand us exactly SCREEN_W, which is the same scroll position as 0.
  function automatic logic [9:0] clamp_offset(input logic [11:0] off);
    return (off >= 12'(SCREEN_W)) ? 10'd0 : off[9:0];
  endfunction

endpackage

// File: rtl/floor_addr_gen.sv
// Combinational floor-band detect and scrolled sprite ROM address for one pixel.
module floor_addr_gen
  import floor_pkg::*;
(
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [9:0]  offset,
  output logic        in_floor,
  output floor_addr_t addr
);

  logic [10:0] col_sum;
  logic [10:0] col;
  logic [8:0]  row;

  // A single conditional subtract suffices because the offset is already below SCREEN_W.
  always_comb begin
    in_floor = (y >= 9'(FLOOR_Y_TOP)) && (y < 9'(FLOOR_Y_TOP + FLOOR_HEIGHT));
    col_sum  = {1'b0, x} + {1'b0, offset};
    col      = (col_sum >= 11'(SCREEN_W)) ? col_sum - 11'(SCREEN_W) : col_sum;
    row      = y - 9'(FLOOR_Y_TOP);
    addr     = floor_addr_t'(row) * floor_addr_t'(SCREEN_W) + floor_addr_t'(col);
  end

endmodule

// File: rtl/floor_renderer.sv
// Three-stage floor pixel pipeline: address, synchronous ROM read, colour/hit.
// FLOOR_FRAME_LATCH_EN: when defined the scroll offset is latched on frame_start (tear-free).
module floor_renderer
  import floor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] floor_offset,
  input  logic        frame_start,
  input  logic        in_valid,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  output floor_addr_t rom_addr,
  input  color_t      rom_data,
  output logic        out_valid,
  output logic        floor_hit,
  output color_t      color
);

  logic [9:0]  live_offset;
  logic [9:0]  stage_offset;
  logic        in_floor;
  floor_addr_t gen_addr;

  assign live_offset = clamp_offset(floor_offset);

`ifdef FLOOR_FRAME_LATCH_EN
  logic [9:0] offset_shadow_d, offset_shadow_q;

  // A request coinciding with frame_start still sees the old shadow value.
  always_comb begin
    offset_shadow_d = frame_start ? live_offset : offset_shadow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) offset_shadow_q <= '0;
    else       offset_shadow_q <= offset_shadow_d;
  end

  assign stage_offset = offset_shadow_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign stage_offset       = live_offset;
`endif

  floor_addr_gen u_addr_gen (
    .x        (x),
    .y        (y),
    .offset   (stage_offset),
    .in_floor (in_floor),
    .addr     (gen_addr)
  );

  floor_addr_t rom_addr_d, rom_addr_q;
  logic        v1_d, v1_q, f1_d, f1_q;
  logic        v2_d, v2_q, f2_d, f2_q;
  logic        out_valid_d, out_valid_q;
  logic        floor_hit_d, floor_hit_q;
  color_t      color_d, color_q;

  always_comb begin
    rom_addr_d  = in_floor ? gen_addr : rom_addr_q;
    v1_d        = in_valid;
    f1_d        = in_floor;
    v2_d        = v1_q;
    f2_d        = f1_q;
    out_valid_d = v2_q;
    floor_hit_d = v2_q && f2_q && (rom_data != TRANSPARENT_KEY);
    color_d     = floor_hit_d ? rom_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_q  <= '0;
      v1_q        <= 1'b0;
      f1_q        <= 1'b0;
      v2_q        <= 1'b0;
      f2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      floor_hit_q <= 1'b0;
      color_q     <= '0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      v1_q        <= v1_d;
      f1_q        <= f1_d;
      v2_q        <= v2_d;
      f2_q        <= f2_d;
      out_valid_q <= out_valid_d;
      floor_hit_q <= floor_hit_d;
      color_q     <= color_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign floor_hit = floor_hit_q;
  assign color     = color_q;

endmodule

// File: tb/tb_floor_renderer.sv
// Bench for floor_renderer: directed pixels plus randomized traffic against a modulo-arithmetic model.
// Follows FLOOR_FRAME_LATCH_EN the same way the design does.
module tb_floor_renderer;
  import floor_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] floor_offset;
  logic        frame_start;
  logic        in_valid;
  logic [9:0]  x;
  logic [8:0]  y;
  floor_addr_t rom_addr;
  color_t      rom_data;
  logic        out_valid;
  logic        floor_hit;
  color_t      color;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  floor_renderer dut (
    .clk          (clk),
    .reset        (reset),
    .floor_offset (floor_offset),
    .frame_start  (frame_start),
    .in_valid     (in_valid),
    .x            (x),
    .y            (y),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .out_valid    (out_valid),
    .floor_hit    (floor_hit),
    .color        (color)
  );

  // Sprite contents: a fixed marker at 0, every 7th word (offset 3) transparent.
  function automatic logic [23:0] rom_func(input int a);
    if (a == 0) return 24'h123456;
    if (a % 7 == 3) return 24'hFF00FF;
    return 24'(a * 2654435 + 24'h010101);
  endfunction

  always @(posedge clk) rom_data <= rom_func(int'(rom_addr));

  typedef struct {
    bit          v;
    bit          hit;
    logic [23:0] col;
  } res_t;

  res_t pipe[3];
  int   exp_addr;
  bit   model_ready = 1'b0;
`ifdef FLOOR_FRAME_LATCH_EN
  int   shadow;
`endif

  // Reference: every accepted pixel's result is known at request time and emerges three edges later.
  always @(posedge clk) begin
    int   off, col, a;
    bit   inf;
    res_t r;
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, hit: 1'b0, col: 24'h0};
      exp_addr    = 0;
      model_ready = 1'b1;
`ifdef FLOOR_FRAME_LATCH_EN
      shadow = 0;
`endif
    end else if (model_ready) begin
`ifdef FLOOR_FRAME_LATCH_EN
      off = shadow;
`else
      off = (int'(floor_offset) >= 640) ? 0 : int'(floor_offset);
`endif
      inf = (int'(y) >= 400) && (int'(y) < 480);
      col = (int'(x) + off) % 640;
      a   = (int'(y) - 400) * 640 + col;
      r.v   = in_valid;
      r.hit = in_valid && inf && (rom_func(a) != 24'hFF00FF);
      r.col = r.hit ? rom_func(a) : 24'h0;
      if (inf) exp_addr = a;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = r;
`ifdef FLOOR_FRAME_LATCH_EN
      if (frame_start) shadow = (int'(floor_offset) >= 640) ? 0 : int'(floor_offset);
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("out_valid", 32'(out_valid), 32'(pipe[2].v));
      checkOutput("floor_hit", 32'(floor_hit), 32'(pipe[2].hit));
      checkOutput("color",     32'(color),     32'(pipe[2].col));
      checkOutput("rom_addr",  32'(rom_addr),  32'(exp_addr));
    end
  end

  // Drives one cycle of inputs and returns at the next falling edge.
  task automatic applyStimulus(input bit rst, input bit fs, input int off,
                               input bit v, input int xx, input int yy);
    reset        = rst;
    frame_start  = fs;
    floor_offset = 12'(off);
    in_valid     = v;
    x            = 10'(xx);
    y            = 9'(yy);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cur_off;
    reset = 1'b1; frame_start = 1'b0; floor_offset = '0; in_valid = 1'b0; x = '0; y = '0;
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset floor_hit", 32'(floor_hit), 32'd0);
    checkOutput("reset color",     32'(color),     32'd0);
    checkOutput("reset rom_addr",  32'(rom_addr),  32'd0);

    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 400);
    checkOutput("t1 rom_addr", 32'(rom_addr), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1 out_valid", 32'(out_valid), 32'd1);
    checkOutput("t1 floor_hit", 32'(floor_hit), 32'd1);
    checkOutput("t1 color",     32'(color),     32'h123456);

    applyStimulus(0, 1, 100, 0, 0, 0);
    applyStimulus(0, 0, 100, 1, 600, 401);
    checkOutput("wrap rom_addr", 32'(rom_addr), 32'd700);
    applyStimulus(0, 0, 100, 0, 0, 0);
    applyStimulus(0, 0, 100, 0, 0, 0);
    checkOutput("wrap floor_hit", 32'(floor_hit), 32'd1);

    applyStimulus(0, 1, 640, 0, 0, 0);
    applyStimulus(0, 0, 640, 1, 5, 400);
    checkOutput("clamp640 rom_addr", 32'(rom_addr), 32'd5);

    applyStimulus(0, 0, 640, 1, 0, 399);
    checkOutput("y399 rom_addr held", 32'(rom_addr), 32'd5);
    applyStimulus(0, 0, 640, 1, 0, 480);
    checkOutput("y480 rom_addr held", 32'(rom_addr), 32'd5);
    applyStimulus(0, 0, 640, 0, 0, 0);
    checkOutput("y399 out_valid", 32'(out_valid), 32'd1);
    checkOutput("y399 floor_hit", 32'(floor_hit), 32'd0);
    checkOutput("y399 color",     32'(color),     32'd0);

    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 3, 400);
    checkOutput("key rom_addr", 32'(rom_addr), 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("key out_valid", 32'(out_valid), 32'd1);
    checkOutput("key floor_hit", 32'(floor_hit), 32'd0);
    checkOutput("key color",     32'(color),     32'd0);

    applyStimulus(0, 1, 10, 0, 0, 0);
    applyStimulus(0, 0, 50, 1, 0, 400);
`ifdef FLOOR_FRAME_LATCH_EN
    checkOutput("latched rom_addr", 32'(rom_addr), 32'd10);
`else
    checkOutput("live rom_addr", 32'(rom_addr), 32'd50);
`endif
    applyStimulus(0, 1, 50, 0, 0, 0);
    applyStimulus(0, 0, 50, 1, 0, 400);
    checkOutput("relatch rom_addr", 32'(rom_addr), 32'd50);

    applyStimulus(0, 0, 50, 1, 0, 400);
    applyStimulus(0, 0, 50, 1, 1, 400);
    applyStimulus(0, 0, 50, 1, 2, 400);
    applyStimulus(1, 0, 50, 0, 0, 0);
    checkOutput("flush out_valid 0", 32'(out_valid), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 50, 0, 0, 0);
      checkOutput($sformatf("flush out_valid %0d", i), 32'(out_valid), 32'd0);
    end

    cur_off = 0;
    for (int i = 0; i < 3000; i++) begin
      int yy;
      if ($urandom_range(0, 19) == 0) cur_off = $urandom_range(0, 640);
      yy = ($urandom_range(0, 1) == 1) ? $urandom_range(390, 479) : $urandom_range(0, 479);
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, cur_off,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 639), yy);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, cur_off, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
